// File: rtl/rv32i_types.sv
// Shared types for the CDB write-back path.
//   sal_t          : one completed result (rdy = valid, tag = ROB index, data = result)
//   cdb_slot_idx_t : index of a CDB slot
//   CDB_SLOTS      : default number of CDB write-back ports per cycle
package rv32i_types;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 6;
  localparam int CDB_SLOTS = 2;

  typedef struct packed {
    logic                 rdy;
    logic [ROB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      data;
  } sal_t;

  typedef logic [$clog2(CDB_SLOTS)-1:0] cdb_slot_idx_t;

endpackage

// File: rtl/cdb_arbiter_chk.sv
// Simulation checker for the CDB arbiter: flags two simultaneously requesting
// requesters that carry the same ROB tag (legal to arbitrate, but an upstream bug).
//   clk, rst : clock and synchronous active-high reset
//   rdy      : per-requester request-valid bits
//   tags     : per-requester ROB tags
module cdb_arbiter_chk
  import rv32i_types::*;
#(
  parameter int NUM_REQ = 17
) (
  input logic                 clk,
  input logic                 rst,
  input logic [NUM_REQ-1:0]   rdy,
  input logic [ROB_TAG_W-1:0] tags [NUM_REQ]
);

  logic dup_s;

  // Pairwise compare of tags among active requesters.
  always_comb begin
    dup_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (rdy[i] && rdy[j] && (tags[i] == tags[j])) begin
          dup_s = 1'b1;
        end else begin
          dup_s = dup_s;
        end
      end
    end
  end

  dup_tag_a: assert property (@(posedge clk) disable iff (rst) !dup_s);

endmodule

// File: rtl/rr_select.sv
// Combinational round-robin picker: returns the one-hot of the first set bit
// of req at or after ptr, wrapping from N-1 back to 0.
//   req  : candidate vector
//   ptr  : scan start index (must be < N)
//   pick : one-hot of the chosen candidate (all zero if req is empty)
//   any  : high when a candidate was chosen
module rr_select #(
  parameter int N  = 17,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  logic found_s;

  // Scan from ptr in wrap-around order and keep only the first hit.
  always_comb begin
    pick    = '0;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found_s && req[idx]) begin
        pick[idx] = 1'b1;
        found_s   = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    any = found_s;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of completed results onto NUM_CDB registered CDB slots.
//   clk, rst         : clock, synchronous active-high reset
//   flush            : squash; no grants this cycle, bus and pointer cleared next cycle
//   req_i[NUM_REQ]   : completed results (.rdy = request valid)
//   grant_o          : per-requester grant, combinational; requester retires on this edge
//   cdb_o[NUM_CDB]   : registered CDB slots, valid for one cycle per grant
//   busy_o           : some request is left ungranted this cycle
// Optional (macro CDB_ARB_PERF_EN):
//   perf_stall_cnt_o : saturating count of cycles with busy_o high
//   perf_grant_cnt_o : saturating count of grants issued
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ = 17,
  parameter int NUM_CDB = CDB_SLOTS,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  sal_t               req_i [NUM_REQ],
  output logic [NUM_REQ-1:0] grant_o,
  output sal_t               cdb_o [NUM_CDB],
  output logic               busy_o
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt_o,
  output logic [31:0]        perf_grant_cnt_o
`endif
);

  localparam int CNT_W = $clog2(NUM_REQ + 1);
  localparam int GN_W  = $clog2(NUM_CDB + 1);

  logic [PTR_W-1:0]     rr_ptr_r;
  logic [NUM_REQ-1:0]   rdy_s;
  logic [NUM_REQ-1:0]   remain_s [NUM_CDB+1];
  logic [NUM_REQ-1:0]   pick_s   [NUM_CDB];
  logic [NUM_CDB-1:0]   any_s;
  logic [NUM_REQ-1:0]   grant_all_s;
  logic [PTR_W-1:0]     last_idx_s;
  logic [PTR_W-1:0]     ptr_next_s;
  logic [CNT_W-1:0]     req_cnt_s;
  logic [GN_W-1:0]      grant_num_s;
  logic                 grant_en_s;
  sal_t                 cdb_next_s [NUM_CDB];
  logic [ROB_TAG_W-1:0] tags_s [NUM_REQ];

  function automatic logic [PTR_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) begin
        r = PTR_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign rdy_s[gi]  = req_i[gi].rdy;
    assign tags_s[gi] = req_i[gi].tag;
  end

  // Slot n picks from what slots 0..n-1 left over, all scanning from rr_ptr,
  // so picks come out in scan order.
  assign remain_s[0] = rdy_s;
  for (genvar gn = 0; gn < NUM_CDB; gn++) begin : g_slot
    rr_select #(.N(NUM_REQ), .PW(PTR_W)) u_sel (
      .req  (remain_s[gn]),
      .ptr  (rr_ptr_r),
      .pick (pick_s[gn]),
      .any  (any_s[gn])
    );
    assign remain_s[gn+1] = remain_s[gn] & ~pick_s[gn];
  end

  assign grant_en_s = ~rst & ~flush;

  // Merge slot picks into the grant vector and build the next CDB contents.
  always_comb begin
    grant_all_s = '0;
    last_idx_s  = '0;
    grant_num_s = '0;
    for (int n = 0; n < NUM_CDB; n++) begin
      grant_all_s   = grant_all_s | pick_s[n];
      cdb_next_s[n] = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pick_s[n][i]) begin
          cdb_next_s[n] = req_i[i];
        end else begin
          cdb_next_s[n] = cdb_next_s[n];
        end
      end
      if (any_s[n]) begin
        last_idx_s  = oh2idx(pick_s[n]);
        grant_num_s = grant_num_s + GN_W'(1);
      end else begin
        last_idx_s  = last_idx_s;
        grant_num_s = grant_num_s;
      end
    end
    if (last_idx_s == PTR_W'(NUM_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = last_idx_s + PTR_W'(1);
    end
  end

  // Count active requests for the busy indication.
  always_comb begin
    req_cnt_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cnt_s = req_cnt_s + CNT_W'(rdy_s[i]);
    end
  end

  assign grant_o = grant_en_s ? grant_all_s : '0;
  assign busy_o  = ~rst & (req_cnt_s > CNT_W'(NUM_CDB));

  // Registered CDB slots; rst and flush discard whatever was just granted.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_CDB; n++) begin
      if (rst || flush) begin
        cdb_o[n] <= '0;
      end else begin
        cdb_o[n] <= cdb_next_s[n];
      end
    end
  end

  // Round-robin pointer moves just past the last granted requester.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr_r <= '0;
    end else if (any_s[0]) begin
      rr_ptr_r <= ptr_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic [32:0] grant_sum_s;
  assign grant_sum_s = {1'b0, perf_grant_cnt_o} + 33'(grant_en_s ? grant_num_s : GN_W'(0));

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_o <= 32'd0;
      perf_grant_cnt_o <= 32'd0;
    end else begin
      if (busy_o && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end else begin
        perf_stall_cnt_o <= perf_stall_cnt_o;
      end
      perf_grant_cnt_o <= grant_sum_s[32] ? 32'hFFFF_FFFF : grant_sum_s[31:0];
    end
  end
`endif

  cdb_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy_s),
    .tags (tags_s)
  );

endmodule
